// File: rtl/fet_scan_unload_if.sv
// Capture/serial-unload port bundle between a flop-bank readback engine and its host/sink.
interface fet_scan_unload_if #(
  parameter int WIDTH = 8
);
  logic             capture;
  logic [WIDTH-1:0] d;
  logic             so;
  logic             so_valid;
  logic             so_last;
  logic             so_ready;
  logic             busy;
  logic             overrun;
  logic             clr_ovr;

  modport master (
    input  capture, d, so_ready, clr_ovr,
    output so, so_valid, so_last, busy, overrun
  );

  modport slave (
    output capture, d, so_ready, clr_ovr,
    input  so, so_valid, so_last, busy, overrun
  );
endinterface

// File: rtl/fet_scan_unload.sv
// Snapshots a flop-bank word on capture and unloads it one bit per valid/ready
// handshake, optionally followed by an even-parity bit.
//
// state | meaning
// IDLE  | no frame; so/so_valid/so_last/busy low, waiting for capture
// SHIFT | frame in progress; cnt_q = bits remaining, so shows the current bit
module fet_scan_unload #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic              clk,
  input  logic              rst,
  fet_scan_unload_if.master bus
);

  localparam int N  = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             par_q, par_d;
  logic             ovr_q, ovr_d;
  logic             xfer, last_bit, final_xfer, accept, so_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    par_d      = par_q;
    ovr_d      = ovr_q;
    xfer       = (state_q == SHIFT) && bus.so_ready;
    last_bit   = (state_q == SHIFT) && (cnt_q == CW'(1));
    final_xfer = xfer && last_bit;
    // A capture landing on the final transfer chains the next frame with no gap.
    accept     = bus.capture && ((state_q == IDLE) || final_xfer);

    if (accept) begin
      sr_d    = bus.d;
      par_d   = ^bus.d;
      cnt_d   = CW'(N);
      state_d = SHIFT;
    end else if (xfer) begin
      if (LSB_FIRST != 0) sr_d = sr_q >> 1;
      else                sr_d = sr_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = IDLE;
    end

    // Set beats clear so a coincident clear cannot hide a fresh overrun.
    if (bus.clr_ovr) ovr_d = 1'b0;
    if (bus.capture && (state_q == SHIFT) && !final_xfer) ovr_d = 1'b1;
  end

  always_comb begin
    so_bit = 1'b0;
    if (state_q == SHIFT) begin
      if ((PARITY != 0) && (cnt_q == CW'(1))) so_bit = par_q;
      else if (LSB_FIRST != 0)                so_bit = sr_q[0];
      else                                    so_bit = sr_q[WIDTH-1];
    end
  end

  assign bus.so       = so_bit;
  assign bus.so_valid = (state_q == SHIFT);
  assign bus.busy     = (state_q == SHIFT);
  assign bus.so_last  = last_bit;
  assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_fet_scan_unload.sv
// Directed bench: dut_a is LSB-first without parity, dut_b is MSB-first with parity.
module tb_fet_scan_unload;

  logic       clk = 1'b0;
  logic       rst;
  logic       capture, so_ready, clr_ovr, sel;
  logic [7:0] d;
  logic       m_so, m_valid, m_last, m_busy, m_ovr;
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  fet_scan_unload_if #(.WIDTH(8)) bus_a ();
  fet_scan_unload_if #(.WIDTH(8)) bus_b ();

  assign bus_a.capture  = capture;
  assign bus_a.d        = d;
  assign bus_a.so_ready = so_ready;
  assign bus_a.clr_ovr  = clr_ovr;
  assign bus_b.capture  = capture;
  assign bus_b.d        = d;
  assign bus_b.so_ready = so_ready;
  assign bus_b.clr_ovr  = clr_ovr;

  fet_scan_unload #(.WIDTH(8), .LSB_FIRST(1), .PARITY(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master));
  fet_scan_unload #(.WIDTH(8), .LSB_FIRST(0), .PARITY(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master));

  always_comb begin
    m_so    = sel ? bus_b.so       : bus_a.so;
    m_valid = sel ? bus_b.so_valid : bus_a.so_valid;
    m_last  = sel ? bus_b.so_last  : bus_a.so_last;
    m_busy  = sel ? bus_b.busy     : bus_a.busy;
    m_ovr   = sel ? bus_b.overrun  : bus_a.overrun;
  end

  typedef struct {
    logic       sel;
    logic [7:0] d;
    logic [3:0] rpat;      // bit k = so_ready in cycle k mod 4 of the frame
    int         n;
    logic [8:0] exp_bits;  // bit i = i-th bit delivered
    logic [8:0] exp_last;
    int         exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] dv);
    d = dv;
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
  endtask

  task automatic collect(input int n, input logic [3:0] rpat, input int cap_at,
                         input logic [7:0] d2, output logic [8:0] bits,
                         output logic [8:0] lasts, output int busy_cnt,
                         output int hold_err, output int got);
    int  cyc = 0;
    logic r, prev_stall = 1'b0, prev_so = 1'b0, prev_last = 1'b0;
    bits = '0; lasts = '0; busy_cnt = 0; hold_err = 0; got = 0;
    while (got < n && cyc < 100) begin
      r = rpat[cyc % 4];
      so_ready = r;
      if (cyc == 2) d = ~d;
      capture = 1'b0;
      if (cyc == cap_at) begin
        capture = 1'b1;
        d = d2;
      end
      if (m_busy) busy_cnt++;
      if (prev_stall && (m_so !== prev_so || m_last !== prev_last)) hold_err++;
      if (m_valid && r) begin
        bits[got]  = m_so;
        lasts[got] = m_last;
        got++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = m_valid;
        prev_so    = m_so;
        prev_last  = m_last;
      end
      cyc++;
      @(negedge clk);
    end
    capture  = 1'b0;
    so_ready = 1'b1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", {31'd0, m_busy}, 32'd0);
  endtask

  logic [8:0] bits, lasts;
  int         busy_cnt, hold_err, got;

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 4'b1111, 8, 9'h0A5, 9'h080, 8};
    vecs[1] = '{1'b1, 8'hA5, 4'b1111, 9, 9'h0A5, 9'h100, 9};
    vecs[2] = '{1'b1, 8'h07, 4'b1111, 9, 9'h1E0, 9'h100, 9};
    vecs[3] = '{1'b0, 8'h3C, 4'b1001, 8, 9'h03C, 9'h080, 16};
    vecs[4] = '{1'b1, 8'h3C, 4'b1001, 9, 9'h03C, 9'h100, 17};
    vecs[5] = '{1'b0, 8'h01, 4'b1111, 8, 9'h001, 9'h080, 8};

    rst = 1'b1; capture = 1'b0; so_ready = 1'b1; clr_ovr = 1'b0; sel = 1'b0; d = 8'h00;
    #12;
    check("reset_a", {27'd0, bus_a.so, bus_a.so_valid, bus_a.so_last, bus_a.busy, bus_a.overrun}, 32'd0);
    check("reset_b", {27'd0, bus_b.so, bus_b.so_valid, bus_b.so_last, bus_b.busy, bus_b.overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      start(vecs[i].d);
      collect(vecs[i].n, vecs[i].rpat, -1, 8'h00, bits, lasts, busy_cnt, hold_err, got);
      check($sformatf("v%0d_len", i), got, vecs[i].n);
      check($sformatf("v%0d_bits", i), {23'd0, bits}, {23'd0, vecs[i].exp_bits});
      check($sformatf("v%0d_last", i), {23'd0, lasts}, {23'd0, vecs[i].exp_last});
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
      check($sformatf("v%0d_stall_hold", i), hold_err, 0);
      check($sformatf("v%0d_end_idle", i), {29'd0, m_valid, m_busy, m_last}, 32'd0);
      repeat (2) @(negedge clk);
    end

    // Overrun mid-frame, clear coinciding with a new overrun, then a plain clear.
    sel = 1'b0;
    check("ovr_initial", {31'd0, m_ovr}, 32'd0);
    start(8'h5A);
    capture = 1'b1; d = 8'hFF;
    @(negedge clk);
    capture = 1'b0;
    check("ovr_set", {31'd0, m_ovr}, 32'd1);
    capture = 1'b1; clr_ovr = 1'b1;
    @(negedge clk);
    capture = 1'b0; clr_ovr = 1'b0;
    check("ovr_clr_collide", {31'd0, m_ovr}, 32'd1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr_cleared", {31'd0, m_ovr}, 32'd0);
    wait_idle();

    // Overrun at bit 3 leaves the frame unaltered.
    start(8'h5A);
    collect(8, 4'b1111, 2, 8'h00, bits, lasts, busy_cnt, hold_err, got);
    check("ovr_frame_bits", {23'd0, bits}, 32'h05A);
    check("ovr_after_frame", {31'd0, m_ovr}, 32'd1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr_clear2", {31'd0, m_ovr}, 32'd0);
    repeat (2) @(negedge clk);

    // Back-to-back: capture 0xFF on the final transfer of a 0xA5 frame.
    start(8'hA5);
    collect(8, 4'b1111, 7, 8'hFF, bits, lasts, busy_cnt, hold_err, got);
    check("b2b_first_bits", {23'd0, bits}, 32'h0A5);
    check("b2b_no_gap", {29'd0, m_valid, m_busy, m_so}, 32'd7);
    collect(8, 4'b1111, -1, 8'h00, bits, lasts, busy_cnt, hold_err, got);
    check("b2b_second_bits", {23'd0, bits}, 32'h0FF);
    check("b2b_second_last", {23'd0, lasts}, 32'h080);
    check("b2b_no_overrun", {31'd0, m_ovr}, 32'd0);
    check("b2b_end_idle", {30'd0, m_valid, m_busy}, 32'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset during bit 4, then a clean frame.
    start(8'hA5);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_a", {27'd0, bus_a.so, bus_a.so_valid, bus_a.so_last, bus_a.busy, bus_a.overrun}, 32'd0);
    check("rst_mid_b", {27'd0, bus_b.so, bus_b.so_valid, bus_b.so_last, bus_b.busy, bus_b.overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start(8'h01);
    collect(8, 4'b1111, -1, 8'h00, bits, lasts, busy_cnt, hold_err, got);
    check("post_rst_bits", {23'd0, bits}, 32'h001);
    check("post_rst_last", {23'd0, lasts}, 32'h080);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
